// File: rtl/sync_stream_fifo.sv
// sync_stream_fifo: single-clock stream FIFO with count and status flags.
// Define SYNC_FIFO_FWFT_EN for a first-word fall-through output stage.
module sync_stream_fifo #(
    parameter int M_WIDTH   = 32,
    parameter int M_DEPTH   = 11,
    parameter int AFULL_TH  = 2**M_DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_write_enable,
    input  logic [M_WIDTH-1:0] i_write_data,
    input  logic               i_read_enable,
    output logic [M_WIDTH-1:0] o_read_data,
    output logic               o_read_data_valid,
    output logic [M_DEPTH:0]   o_count,
    output logic               o_empty,
    output logic               o_full,
    output logic               o_almost_full,
    output logic               o_almost_empty,
    output logic               o_overflow,
    output logic               o_underflow
);

    localparam int DEPTH = 2**M_DEPTH;
    localparam logic [M_DEPTH:0] CAP    = (M_DEPTH+1)'(DEPTH);
    localparam logic [M_DEPTH:0] AF_LVL = (M_DEPTH+1)'(AFULL_TH);
    localparam logic [M_DEPTH:0] AE_LVL = (M_DEPTH+1)'(AEMPTY_TH);

    generate
        if (!(AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_bad_th
            $error("sync_stream_fifo: need AEMPTY_TH < AFULL_TH <= depth");
        end
    endgenerate

    logic [M_WIDTH-1:0] ram [DEPTH];
    logic [M_DEPTH:0]   wr_ptr;
    logic [M_DEPTH:0]   rd_ptr;
    logic [M_DEPTH:0]   count_next;
    logic [M_DEPTH:0]   count_d;
    logic [M_DEPTH-1:0] rd_addr;
    logic               pop;
    logic               push;
    logic               ovf_evt;
    logic               unf_evt;
    logic               wr_inc;
    logic               rd_inc;
    logic               ram_we;

    assign rd_addr = rd_ptr[M_DEPTH-1:0];

`ifdef SYNC_FIFO_FWFT_EN
    logic ram_empty;
    logic stage_take;
    logic load_ram;
    logic bypass;

    assign pop     = i_read_enable && o_read_data_valid;
    assign unf_evt = i_read_enable && !o_read_data_valid;
`else
    assign pop     = i_read_enable && !o_empty;
    assign unf_evt = i_read_enable && o_empty;
`endif

    assign push    = i_write_enable && (!o_full || pop);
    assign ovf_evt = i_write_enable && !push;

    always_comb begin
        count_next = o_count;
        unique case ({push, pop})
            2'b10:   count_next = o_count + 1'b1;
            2'b01:   count_next = o_count - 1'b1;
            default: count_next = o_count;
        endcase
        count_d = i_clear ? '0 : count_next;
    end

    // Flags come from the next-state count so they line up with o_count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_count        <= '0;
            o_empty        <= 1'b1;
            o_full         <= 1'b0;
            o_almost_full  <= 1'b0;
            o_almost_empty <= 1'b1;
            o_overflow     <= 1'b0;
            o_underflow    <= 1'b0;
        end else begin
            o_count        <= count_d;
            o_empty        <= (count_d == '0);
            o_full         <= (count_d == CAP);
            o_almost_full  <= (count_d >= AF_LVL);
            o_almost_empty <= (count_d <= AE_LVL);
            if (i_clear) begin
                o_overflow  <= 1'b0;
                o_underflow <= 1'b0;
            end else begin
                o_overflow  <= o_overflow | ovf_evt;
                o_underflow <= o_underflow | unf_evt;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign ram_empty  = (wr_ptr == rd_ptr);
    assign stage_take = !o_read_data_valid || pop;
    assign load_ram   = stage_take && !ram_empty;
    // An empty FIFO lets the incoming word skip the RAM.
    assign bypass     = stage_take && ram_empty && push;
    assign wr_inc     = push && !bypass;
    assign rd_inc     = load_ram;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_read_data       <= '0;
            o_read_data_valid <= 1'b0;
        end else if (i_clear) begin
            o_read_data_valid <= 1'b0;
        end else if (stage_take) begin
            if (load_ram) begin
                o_read_data       <= ram[rd_addr];
                o_read_data_valid <= 1'b1;
            end else if (bypass) begin
                o_read_data       <= i_write_data;
                o_read_data_valid <= 1'b1;
            end else begin
                o_read_data_valid <= 1'b0;
            end
        end
    end
`else
    assign wr_inc = push;
    assign rd_inc = pop;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_read_data       <= '0;
            o_read_data_valid <= 1'b0;
        end else if (i_clear) begin
            o_read_data_valid <= 1'b0;
        end else begin
            o_read_data_valid <= pop;
            if (pop) begin
                o_read_data <= ram[rd_addr];
            end
        end
    end
`endif

    assign ram_we = wr_inc && !i_clear;

    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            ram[wr_ptr[M_DEPTH-1:0]] <= i_write_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_inc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_inc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_stream_fifo.sv
// tb_sync_stream_fifo: directed and random checks against a queue model.
// Works with or without SYNC_FIFO_FWFT_EN.
module tb_sync_stream_fifo;

    localparam int W    = 8;
    localparam int D    = 2;
    localparam int CAPN = 4;
    localparam int AFT  = 3;
    localparam int AET  = 1;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_clear = 1'b0;
    logic         i_write_enable = 1'b0;
    logic [W-1:0] i_write_data = '0;
    logic         i_read_enable = 1'b0;
    logic [W-1:0] o_read_data;
    logic         o_read_data_valid;
    logic [D:0]   o_count;
    logic         o_empty;
    logic         o_full;
    logic         o_almost_full;
    logic         o_almost_empty;
    logic         o_overflow;
    logic         o_underflow;

    always #5 i_clk = ~i_clk;

    sync_stream_fifo #(
        .M_WIDTH  (W),
        .M_DEPTH  (D),
        .AFULL_TH (AFT),
        .AEMPTY_TH(AET)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_clear          (i_clear),
        .i_write_enable   (i_write_enable),
        .i_write_data     (i_write_data),
        .i_read_enable    (i_read_enable),
        .o_read_data      (o_read_data),
        .o_read_data_valid(o_read_data_valid),
        .o_count          (o_count),
        .o_empty          (o_empty),
        .o_full           (o_full),
        .o_almost_full    (o_almost_full),
        .o_almost_empty   (o_almost_empty),
        .o_overflow       (o_overflow),
        .o_underflow      (o_underflow)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    logic         m_ovf;
    logic         m_unf;
    logic         m_valid;
    logic [W-1:0] m_data;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = q.size();
        chk({ctx, ".count"}, 32'(o_count), 32'(n));
        chk({ctx, ".empty"}, 32'(o_empty), 32'(n == 0));
        chk({ctx, ".full"}, 32'(o_full), 32'(n == CAPN));
        chk({ctx, ".afull"}, 32'(o_almost_full), 32'(n >= AFT));
        chk({ctx, ".aempty"}, 32'(o_almost_empty), 32'(n <= AET));
        chk({ctx, ".ovf"}, 32'(o_overflow), 32'(m_ovf));
        chk({ctx, ".unf"}, 32'(o_underflow), 32'(m_unf));
        chk({ctx, ".valid"}, 32'(o_read_data_valid), 32'(m_valid));
        chk({ctx, ".data"}, 32'(o_read_data), 32'(m_data));
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    task automatic step(input string ctx, input logic clr, input logic we,
                        input logic [W-1:0] wd, input logic re);
        int n;
        logic ra;
        logic wa;
        logic [W-1:0] popped;
        i_clear        = clr;
        i_write_enable = we;
        i_write_data   = wd;
        i_read_enable  = re;
        @(posedge i_clk);
        n = q.size();
        popped = '0;
        if (clr) begin
            q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b0;
        end else begin
            ra = re && (n > 0);
            wa = we && ((n < CAPN) || ra);
            if (we && !wa) m_ovf = 1'b1;
            if (re && n == 0) m_unf = 1'b1;
            if (ra) popped = q.pop_front();
            if (wa) q.push_back(wd);
`ifdef SYNC_FIFO_FWFT_EN
            m_valid = (q.size() > 0);
            if (m_valid) m_data = q[0];
`else
            m_valid = ra;
            if (ra) m_data = popped;
`endif
        end
        #1;
        check_all(ctx);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check_all("reset");
        i_rst = 1'b0;

        step("t1.w11", 0, 1, 8'h11, 0);
        step("t1.w22", 0, 1, 8'h22, 0);
        step("t1.w33", 0, 1, 8'h33, 0);
        step("t1.w44", 0, 1, 8'h44, 0);

        step("t2.ovf", 0, 1, 8'h55, 0);
        for (int i = 0; i < 4; i++) step("t2.rd", 0, 0, 8'h00, 1);
        step("t2.idle", 0, 0, 8'h00, 0);

        step("t3.clr", 1, 0, 8'h00, 0);
        step("t3.w11", 0, 1, 8'h11, 0);
        step("t3.w22", 0, 1, 8'h22, 0);
        step("t3.w33", 0, 1, 8'h33, 0);
        step("t3.w44", 0, 1, 8'h44, 0);
        step("t3.rw66", 0, 1, 8'h66, 1);
        for (int i = 0; i < 4; i++) step("t3.rd", 0, 0, 8'h00, 1);

        step("t4.rw77", 0, 1, 8'h77, 1);
        step("t4.rd77", 0, 0, 8'h00, 1);

        step("t5.clr", 1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) step("t5.w", 0, 1, 8'(8'hA0 + i), 0);
        step("t5.ovf", 0, 1, 8'hAF, 0);
        step("t5.rd", 0, 0, 8'h00, 1);
        step("t5.clrwr", 1, 1, 8'hBB, 1);
        step("t5.idle", 0, 0, 8'h00, 0);

        step("t6.w1", 0, 1, 8'h81, 0);
        step("t6.w2", 0, 1, 8'h82, 0);
        i_write_enable = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        model_reset();
        check_all("t6.async_rst");
        #1;
        i_rst = 1'b0;
        step("t6.w99", 0, 1, 8'h99, 0);
        step("t6.idle", 0, 0, 8'h00, 0);
        step("t6.rd99", 0, 0, 8'h00, 1);

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)),
                 8'($urandom),
                 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
